// File: rtl/lcd_spi_init_sequencer.sv
// LCD 3-wire SPI sequencer: replays a ROM init script (cmd/data/delay/end), then hands the link to a host port.
// One 9-bit frame per host_valid/host_ready handshake; host_ready is held low until the script has finished.
module lcd_spi_init_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int DELAY_UNIT = 50000,
  parameter int ADDR_W     = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  input  logic              init_restart,
  input  logic              host_valid,
  input  logic              host_dc,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  output logic              init_done,
  output logic              busy,
  output logic              lcd_sclk,
  output logic              lcd_cs_n,
  output logic              lcd_sdi
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW   = 8 + $clog2(DELAY_UNIT);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_SHIFT, S_GAP, S_DELAY, S_ADVANCE, S_DONE, S_HOST_IDLE
  } state_t;

  state_t          state, state_nxt;
  logic [DIVW-1:0] div_cnt;
  logic            div_end;
  logic            sclk_hi;
  logic [3:0]      bit_cnt;
  logic [8:0]      shreg;
  logic [DW-1:0]   dly_cnt;
  logic            host_frame;
  logic            restart;

  assign div_end = (div_cnt == DIVW'(CLK_DIV - 1));
  assign restart = init_restart && (state == S_DONE || state == S_HOST_IDLE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_FETCH;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (rom_data[9:8])
          2'b00, 2'b01: state_nxt = S_SHIFT;
          2'b10:        state_nxt = (rom_data[7:0] == 8'd0) ? S_ADVANCE : S_DELAY;
          default:      state_nxt = S_DONE;
        endcase
      end
      S_SHIFT:  if (div_end && sclk_hi && bit_cnt == 4'd8) state_nxt = S_GAP;
      S_GAP:    if (div_end) state_nxt = host_frame ? S_HOST_IDLE : S_ADVANCE;
      S_DELAY:  if (dly_cnt == '0) state_nxt = S_ADVANCE;
      S_ADVANCE: state_nxt = (&rom_addr) ? S_DONE : S_FETCH;
      S_DONE:   state_nxt = init_restart ? S_FETCH : S_HOST_IDLE;
      S_HOST_IDLE: begin
        if (init_restart)    state_nxt = S_FETCH;
        else if (host_valid) state_nxt = S_SHIFT;
      end
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rom_addr   <= '0;
      init_done  <= 1'b0;
      div_cnt    <= '0;
      sclk_hi    <= 1'b0;
      bit_cnt    <= 4'd0;
      shreg      <= 9'd0;
      dly_cnt    <= '0;
      host_frame <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          // type[0] doubles as the dc bit for command/data words
          if (state_nxt == S_SHIFT) begin
            shreg      <= rom_data[8:0];
            host_frame <= 1'b0;
          end else if (state_nxt == S_DELAY) begin
            dly_cnt <= DW'(rom_data[7:0]) * DW'(DELAY_UNIT) - DW'(1);
          end
        end
        S_HOST_IDLE: begin
          if (state_nxt == S_SHIFT) begin
            shreg      <= {host_dc, host_data};
            host_frame <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (div_end) begin
            sclk_hi <= !sclk_hi;
            if (sclk_hi) begin
              shreg   <= {shreg[7:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_DELAY:   dly_cnt <= dly_cnt - DW'(1);
        S_ADVANCE: if (!(&rom_addr)) rom_addr <= rom_addr + ADDR_W'(1);
        default: ;
      endcase

      if (restart) begin
        rom_addr  <= '0;
        init_done <= 1'b0;
      end else if (state_nxt == S_DONE) begin
        init_done <= 1'b1;
      end

      // every state entry restarts the half-period timer and bit position
      if (state_nxt != state) begin
        div_cnt <= '0;
        sclk_hi <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (state == S_SHIFT || state == S_GAP) begin
        div_cnt <= div_end ? '0 : div_cnt + DIVW'(1);
      end
    end
  end

  assign lcd_cs_n   = (state != S_SHIFT);
  assign lcd_sclk   = (state == S_SHIFT) && sclk_hi;
  assign lcd_sdi    = (state == S_SHIFT) && shreg[8];
  assign busy       = (state == S_SHIFT) || (state == S_GAP) || (state == S_DELAY);
  assign host_ready = (state == S_HOST_IDLE) && !init_restart;

endmodule

// File: tb/tb_lcd_spi_init_sequencer.sv
// Bench for lcd_spi_init_sequencer: directed ROM scripts and host traffic; expected frames go
// into a scoreboard queue and a pin-level monitor decodes each SPI frame and pops/compares.
module tb_lcd_spi_init_sequencer;
  localparam int CLK_DIV    = 4;
  localparam int DELAY_UNIT = 10;
  localparam int ADDR_W     = 8;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [9:0]        rom_data = 10'd0;
  logic              init_restart = 1'b0;
  logic              host_valid = 1'b0;
  logic              host_dc = 1'b0;
  logic [7:0]        host_data = 8'd0;
  logic              host_ready, init_done, busy, lcd_sclk, lcd_cs_n, lcd_sdi;

  lcd_spi_init_sequencer #(.CLK_DIV(CLK_DIV), .DELAY_UNIT(DELAY_UNIT), .ADDR_W(ADDR_W)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .init_restart(init_restart), .host_valid(host_valid), .host_dc(host_dc), .host_data(host_data),
    .host_ready(host_ready), .init_done(init_done), .busy(busy),
    .lcd_sclk(lcd_sclk), .lcd_cs_n(lcd_cs_n), .lcd_sdi(lcd_sdi)
  );

  always #5 clk_clk = ~clk_clk;

  logic [9:0] rom [256];
  always @(posedge clk_clk) rom_data <= rom[rom_addr];

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_cs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, have_gap = 1'b0;
  logic hr_bad = 1'b0, hr_early = 1'b0;
  int   cs_len = 0, nbits = 0, gap = 0, gap_busy = 0, last_gap = 0, last_gap_busy = 0;
  int   accepts = 0;
  logic [8:0] frame = 9'd0;

  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      in_frame = 1'b0; prev_cs = 1'b1; prev_sclk = 1'b0; have_gap = 1'b0; gap = 0; gap_busy = 0;
    end else begin
      if (host_valid && host_ready) accepts++;
      if (!init_done && host_ready) hr_early = 1'b1;
      if (prev_cs && !lcd_cs_n) begin
        if (have_gap) check("cs_gap_min", 32'(gap >= CLK_DIV), 1);
        last_gap = gap; last_gap_busy = gap_busy;
        in_frame = 1'b1; cs_len = 0; nbits = 0; frame = 9'd0; hr_bad = 1'b0;
      end
      if (!lcd_cs_n) begin
        cs_len++;
        if (!prev_sclk && lcd_sclk) begin
          frame = {frame[7:0], lcd_sdi};
          nbits++;
        end
        if (host_ready) hr_bad = 1'b1;
      end else begin
        if (!prev_cs && in_frame) begin
          check("cs_low_len", cs_len, 18 * CLK_DIV);
          check("frame_bits", nbits, 9);
          check("sdi_idle_at_cs_rise", {31'd0, lcd_sdi}, 0);
          check("ready_low_in_frame", {31'd0, hr_bad}, 0);
          if (exp_q.size() == 0) check("unexpected_frame", {23'd0, frame}, 32'h1ff);
          else                   check("frame_value", {23'd0, frame}, {23'd0, exp_q.pop_front()});
          in_frame = 1'b0; gap = 0; gap_busy = 0; have_gap = 1'b1;
        end
        gap++;
        if (busy) gap_busy++;
      end
      prev_cs = lcd_cs_n; prev_sclk = lcd_sclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_rom(input logic [9:0] w0, input logic [9:0] w1, input logic [9:0] w2,
                          input logic [9:0] w3, input logic [9:0] fill);
    for (int i = 0; i < 256; i++) rom[i] = fill;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  task automatic do_reset(input string tag);
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    check({tag, "_rst_cs_n"}, {31'd0, lcd_cs_n}, 1);
    check({tag, "_rst_sclk"}, {31'd0, lcd_sclk}, 0);
    check({tag, "_rst_sdi"}, {31'd0, lcd_sdi}, 0);
    check({tag, "_rst_addr"}, {24'd0, rom_addr}, 0);
    check({tag, "_rst_done"}, {31'd0, init_done}, 0);
    check({tag, "_rst_ready"}, {31'd0, host_ready}, 0);
    check({tag, "_rst_busy"}, {31'd0, busy}, 0);
    accepts = 0; hr_early = 1'b0;
    reset_reset_n = 1'b1;
  endtask

  task automatic wait_init_done(input string tag, input int max_cyc);
    int n = 0;
    while (!init_done && n < max_cyc) begin
      @(negedge clk_clk);
      n++;
    end
    if (!init_done) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_ready_in_done"}, {31'd0, host_ready}, 0);
      @(negedge clk_clk);
      check({tag, "_ready_idle"}, {31'd0, host_ready}, 1);
    end
  endtask

  task automatic wait_q_empty(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || !lcd_cs_n) && n < max_cyc) begin
      @(negedge clk_clk);
      n++;
    end
    check({tag, "_frames_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // 1: command + data frames, then end marker
    load_rom(10'h02C, 10'h155, 10'h300, 10'h300, 10'h300);
    exp_q.push_back(9'h02C); exp_q.push_back(9'h155);
    do_reset("t1");
    wait_init_done("t1", 3000);
    check("t1_frames_before_done", exp_q.size(), 0);

    // 2: 2-unit delay between two commands
    load_rom(10'h011, 10'h202, 10'h029, 10'h300, 10'h300);
    exp_q.push_back(9'h011); exp_q.push_back(9'h029);
    do_reset("t2");
    wait_init_done("t2", 3000);
    check("t2_frames_before_done", exp_q.size(), 0);
    check("t2_gap_ge_20", 32'(last_gap >= 2 * DELAY_UNIT), 1);
    check("t2_busy_in_gap", last_gap_busy, CLK_DIV + 2 * DELAY_UNIT);

    // 3/4: host request held from reset through init, then for three frames
    load_rom(10'h02C, 10'h155, 10'h300, 10'h300, 10'h300);
    exp_q.push_back(9'h02C); exp_q.push_back(9'h155);
    for (int i = 0; i < 3; i++) exp_q.push_back(9'h1A5);
    host_valid = 1'b1; host_dc = 1'b1; host_data = 8'hA5;
    do_reset("t3");
    wait_init_done("t3", 3000);
    check("t4_ready_held_off", {31'd0, hr_early}, 0);
    n = 0;
    while (accepts < 3 && n < 2000) begin
      @(negedge clk_clk);
      n++;
    end
    @(posedge clk_clk); #1;
    host_valid = 1'b0;
    wait_q_empty("t3", 2000);
    repeat (200) @(negedge clk_clk);
    check("t3_accepts", accepts, 3);

    // 5: reset during the high half of bit 4 of the first frame
    load_rom(10'h155, 10'h02C, 10'h300, 10'h300, 10'h300);
    exp_q.push_back(9'h155); exp_q.push_back(9'h02C);
    do_reset("t5");
    n = 0;
    do begin
      @(negedge clk_clk); #1;
      n++;
    end while (!(nbits == 5 && lcd_sclk && !lcd_cs_n) && n < 2000);
    check("t5_mid_sclk", {31'd0, lcd_sclk}, 1);
    check("t5_mid_sdi", {31'd0, lcd_sdi}, 1);
    reset_reset_n = 1'b0; #1;
    check("t5_abort_cs_n", {31'd0, lcd_cs_n}, 1);
    check("t5_abort_sclk", {31'd0, lcd_sclk}, 0);
    check("t5_abort_sdi", {31'd0, lcd_sdi}, 0);
    check("t5_abort_addr", {24'd0, rom_addr}, 0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    wait_init_done("t5", 3000);
    check("t5_replay_frames", exp_q.size(), 0);

    // 6: restart beats a simultaneous host request; script with no end marker
    load_rom(10'h0C3, 10'h200, 10'h200, 10'h200, 10'h200);
    exp_q.push_back(9'h0C3); exp_q.push_back(9'h0C3);
    do_reset("t6");
    wait_init_done("t6", 3000);
    check("t6_last_addr", {24'd0, rom_addr}, 255);
    host_valid = 1'b1; host_dc = 1'b1; host_data = 8'h77; init_restart = 1'b1;
    #1;
    check("t6_ready_vs_restart", {31'd0, host_ready}, 0);
    @(posedge clk_clk); #1;
    init_restart = 1'b0; host_valid = 1'b0;
    check("t6_done_cleared", {31'd0, init_done}, 0);
    check("t6_addr_cleared", {24'd0, rom_addr}, 0);
    wait_init_done("t6b", 3000);
    check("t6_rerun_frames", exp_q.size(), 0);
    check("t6_rerun_last_addr", {24'd0, rom_addr}, 255);
    check("t6_no_host_accept", accepts, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
